// File: rtl/psg_pkg.sv
// Shared constants and types for the PSG bus sequencer: bus phase encodings,
// register indices and the sequencer state enum.
package psg_pkg;

    // Bus phases as {bdir, bc1}; bc2 is tied high at the PSG.
    localparam logic [1:0] BUS_IDLE = 2'b00;
    localparam logic [1:0] BUS_RD   = 2'b01;
    localparam logic [1:0] BUS_WR   = 2'b10;
    localparam logic [1:0] BUS_ADDR = 2'b11;

    localparam logic [3:0] ADDRMASK_DEFAULT = 4'b0000;

    localparam logic [3:0] R_MIXER     = 4'd7;
    localparam logic [3:0] R_ENV_SHAPE = 4'd13;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        GAP,
        DATA,
        END
    } state_t;

    function automatic logic [1:0] data_phase(input logic we);
        return we ? BUS_WR : BUS_RD;
    endfunction

endpackage

// File: rtl/psg_rr_arb.sv
// Two-way request arbiter: one-hot grant, optional alternation between ports
// when both are requesting. The pointer only moves on an accepted request.
module psg_rr_arb
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] i_valid,
    input  logic       i_accept,
    output logic [1:0] o_grant
);

    logic r_last;   // port granted on the most recent accept

    // NOTE: o_grant gets a default before any branch so no latch is inferred.
    always_comb begin
        o_grant = 2'b00;
        if (i_valid == 2'b11) begin
            o_grant = (ROUND_ROBIN && !r_last) ? 2'b10 : 2'b01;
        end else begin
            o_grant = i_valid;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (i_accept) begin
            r_last <= o_grant[1];
        end
    end

endmodule

// File: rtl/psg_bus_arb.sv
// Arbitrates two register-access ports onto the AY-3-891x bus and sequences
// each request as ADDR / GAP / DATA / END phases paced by the PSG clock enable.
module psg_bus_arb
    import psg_pkg::*;
#(
    parameter logic [3:0] ADDRMASK    = ADDRMASK_DEFAULT,
    parameter bit         ROUND_ROBIN = 1'b1,
    parameter bit         ADDR_CACHE  = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       r0_valid,
    output logic       r0_ready,
    input  logic       r0_we,
    input  logic [3:0] r0_addr,
    input  logic [7:0] r0_wdata,
    output logic       r0_rvalid,
    output logic [7:0] r0_rdata,
    input  logic       r1_valid,
    output logic       r1_ready,
    input  logic       r1_we,
    input  logic [3:0] r1_addr,
    input  logic [7:0] r1_wdata,
    output logic       r1_rvalid,
    output logic [7:0] r1_rdata,
    output logic       psg_bdir,
    output logic       psg_bc1,
    output logic [7:0] psg_d,
    input  logic [7:0] psg_q,
    output logic       busy
);

    state_t     r_state;
    logic       r_we;
    logic [3:0] r_addr;
    logic [7:0] r_wdata;
    logic       r_port;
    logic       r_cache_valid;
    logic [3:0] r_cache_addr;
    logic [1:0] r_bus;
    logic [7:0] r_d;
    logic [1:0] r_rvalid;
    logic [7:0] r_rdata0;
    logic [7:0] r_rdata1;

    logic [1:0] w_grant;
    logic [1:0] w_ready;
    logic       w_xfer;
    logic       w_port;
    logic       w_we;
    logic [3:0] w_addr;
    logic [7:0] w_wdata;
    logic       w_hit;

    psg_rr_arb #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_arb (
        .clock    (clock),
        .reset    (reset),
        .i_valid  ({r1_valid, r0_valid}),
        .i_accept (w_xfer),
        .o_grant  (w_grant)
    );

    // Requests are only taken in IDLE; anything arriving mid-sequence waits.
    assign w_ready = (r_state == IDLE) ? w_grant : 2'b00;
    assign w_xfer  = |(w_ready & {r1_valid, r0_valid});
    assign w_port  = w_grant[1];
    assign w_we    = w_port ? r1_we    : r0_we;
    assign w_addr  = w_port ? r1_addr  : r0_addr;
    assign w_wdata = w_port ? r1_wdata : r0_wdata;
    assign w_hit   = ADDR_CACHE && r_cache_valid && (r_cache_addr == w_addr);

    // NOTE: all state below uses non-blocking assignments so every register
    // sees pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_we          <= 1'b0;
            r_addr        <= 4'h0;
            r_wdata       <= 8'h00;
            r_port        <= 1'b0;
            r_cache_valid <= 1'b0;
            r_cache_addr  <= 4'h0;
            r_bus         <= BUS_IDLE;
            r_d           <= 8'h00;
            r_rvalid      <= 2'b00;
            r_rdata0      <= 8'h00;
            r_rdata1      <= 8'h00;
        end else begin
            r_rvalid <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_we    <= w_we;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_port  <= w_port;
                        if (w_hit) begin
                            r_state <= DATA;
                            r_bus   <= data_phase(w_we);
                            r_d     <= w_we ? w_wdata : 8'h00;
                        end else begin
                            r_state <= ADDR;
                            r_bus   <= BUS_ADDR;
                            r_d     <= {ADDRMASK, w_addr};
                        end
                    end
                end
                ADDR: begin
                    if (ce) begin
                        r_state       <= GAP;
                        r_bus         <= BUS_IDLE;
                        r_d           <= 8'h00;
                        r_cache_addr  <= r_addr;
                        r_cache_valid <= 1'b1;
                    end
                end
                GAP: begin
                    if (ce) begin
                        r_state <= DATA;
                        r_bus   <= data_phase(r_we);
                        r_d     <= r_we ? r_wdata : 8'h00;
                    end
                end
                DATA: begin
                    if (ce) begin
                        r_state <= END;
                        r_bus   <= BUS_IDLE;
                        r_d     <= 8'h00;
                        if (!r_we) begin
                            r_rvalid[r_port] <= 1'b1;
                            if (r_port) r_rdata1 <= psg_q;
                            else        r_rdata0 <= psg_q;
                        end
                    end
                end
                END: begin
                    if (ce) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign r0_ready  = w_ready[0];
    assign r1_ready  = w_ready[1];
    assign r0_rvalid = r_rvalid[0];
    assign r1_rvalid = r_rvalid[1];
    assign r0_rdata  = r_rdata0;
    assign r1_rdata  = r_rdata1;
    assign psg_bdir  = r_bus[1];
    assign psg_bc1   = r_bus[0];
    assign psg_d     = r_d;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_psg_bus_arb.sv
// Bench for psg_bus_arb: two instances (round-robin and fixed priority) share
// stimulus; a transaction-level model is compared every cycle, plus directed literals.
module tb_psg_bus_arb;
    import psg_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b0;
    logic       r0_valid = 1'b0, r0_we = 1'b0;
    logic [3:0] r0_addr = 4'h0;
    logic [7:0] r0_wdata = 8'h00;
    logic       r1_valid = 1'b0, r1_we = 1'b0;
    logic [3:0] r1_addr = 4'h0;
    logic [7:0] r1_wdata = 8'h00;
    logic [7:0] psg_q = 8'h00;

    logic [1:0] r0_ready_o, r1_ready_o, r0_rvalid_o, r1_rvalid_o;
    logic [1:0] bdir_o, bc1_o, busy_o;
    logic [7:0] r0_rdata_o [2];
    logic [7:0] r1_rdata_o [2];
    logic [7:0] d_o [2];

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  cmp_en  = 1'b0;
    bit  ce_run  = 1'b1;
    int  ce_cnt  = 0;
    int  log_a[$];
    int  log_b[$];

    always #5 clock = ~clock;

    // Instance 0 alternates under contention, instance 1 always favours port 0.
    for (genvar k = 0; k < 2; k++) begin : g_dut
        psg_bus_arb #(
            .ADDRMASK    (4'b0000),
            .ROUND_ROBIN (k == 0),
            .ADDR_CACHE  (1'b1)
        ) u_dut (
            .clock     (clock),
            .reset     (reset),
            .ce        (ce),
            .r0_valid  (r0_valid),
            .r0_ready  (r0_ready_o[k]),
            .r0_we     (r0_we),
            .r0_addr   (r0_addr),
            .r0_wdata  (r0_wdata),
            .r0_rvalid (r0_rvalid_o[k]),
            .r0_rdata  (r0_rdata_o[k]),
            .r1_valid  (r1_valid),
            .r1_ready  (r1_ready_o[k]),
            .r1_we     (r1_we),
            .r1_addr   (r1_addr),
            .r1_wdata  (r1_wdata),
            .r1_rvalid (r1_rvalid_o[k]),
            .r1_rdata  (r1_rdata_o[k]),
            .psg_bdir  (bdir_o[k]),
            .psg_bc1   (bc1_o[k]),
            .psg_d     (d_o[k]),
            .psg_q     (psg_q),
            .busy      (busy_o[k])
        );
    end

    task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Transaction model: a request becomes a list of bus phases, one per ce edge.
    bit         m_busy [2];
    int         m_step [2];
    bit         m_cached [2];
    bit         m_we [2];
    logic [3:0] m_addr [2];
    logic [7:0] m_wdata [2];
    int         m_port [2];
    int         m_last [2];
    bit         m_cv [2];
    logic [3:0] m_ca [2];
    bit         m_rv [2][2];
    logic [7:0] m_rd [2][2];

    function automatic int m_grant(input int k);
        if (r0_valid && r1_valid) return (k == 0 && m_last[k] == 0) ? 1 : 0;
        if (r0_valid) return 0;
        if (r1_valid) return 1;
        return -1;
    endfunction

    // 0 = address, 1 = gap, 2 = data, 3 = end
    function automatic int m_phase(input int k);
        return m_cached[k] ? m_step[k] + 2 : m_step[k];
    endfunction

    function automatic logic [1:0] m_bus(input int k);
        if (!m_busy[k]) return 2'b00;
        case (m_phase(k))
            0:       return 2'b11;
            2:       return m_we[k] ? 2'b10 : 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [7:0] m_d(input int k);
        if (!m_busy[k]) return 8'h00;
        if (m_phase(k) == 0) return {4'b0000, m_addr[k]};
        if (m_phase(k) == 2 && m_we[k]) return m_wdata[k];
        return 8'h00;
    endfunction

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            int g;
            g = m_grant(k);
            if (reset) begin
                m_busy[k] <= 1'b0;
                m_step[k] <= 0;
                m_last[k] <= 1;
                m_cv[k]   <= 1'b0;
                m_rv[k][0] <= 1'b0;
                m_rv[k][1] <= 1'b0;
                m_rd[k][0] <= 8'h00;
                m_rd[k][1] <= 8'h00;
            end else begin
                m_rv[k][0] <= 1'b0;
                m_rv[k][1] <= 1'b0;
                if (!m_busy[k]) begin
                    if (g >= 0) begin
                        m_busy[k]   <= 1'b1;
                        m_step[k]   <= 0;
                        m_port[k]   <= g;
                        m_last[k]   <= g;
                        m_we[k]     <= (g == 1) ? r1_we : r0_we;
                        m_addr[k]   <= (g == 1) ? r1_addr : r0_addr;
                        m_wdata[k]  <= (g == 1) ? r1_wdata : r0_wdata;
                        m_cached[k] <= m_cv[k] && (m_ca[k] == ((g == 1) ? r1_addr : r0_addr));
                    end
                end else if (ce) begin
                    if (m_phase(k) == 0) begin
                        m_cv[k] <= 1'b1;
                        m_ca[k] <= m_addr[k];
                    end
                    if (m_phase(k) == 2 && !m_we[k]) begin
                        m_rv[k][m_port[k]] <= 1'b1;
                        m_rd[k][m_port[k]] <= psg_q;
                    end
                    if (m_step[k] + 1 == (m_cached[k] ? 2 : 4)) m_busy[k] <= 1'b0;
                    m_step[k] <= m_step[k] + 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                check("m_ready0", k, r0_ready_o[k], !m_busy[k] && m_grant(k) == 0);
                check("m_ready1", k, r1_ready_o[k], !m_busy[k] && m_grant(k) == 1);
                check("m_bus", k, {bdir_o[k], bc1_o[k]}, m_bus(k));
                check("m_d", k, d_o[k], m_d(k));
                check("m_busy", k, busy_o[k], m_busy[k]);
                check("m_rvalid0", k, r0_rvalid_o[k], m_rv[k][0]);
                check("m_rvalid1", k, r1_rvalid_o[k], m_rv[k][1]);
                check("m_rdata0", k, r0_rdata_o[k], m_rd[k][0]);
                check("m_rdata1", k, r1_rdata_o[k], m_rd[k][1]);
            end
            if (r0_valid && r0_ready_o[0]) log_a.push_back(0);
            if (r1_valid && r1_ready_o[0]) log_a.push_back(1);
            if (r0_valid && r0_ready_o[1]) log_b.push_back(0);
            if (r1_valid && r1_ready_o[1]) log_b.push_back(1);
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            ce_cnt++;
            ce = ce_run && (ce_cnt % 4 == 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Leaves the bench 2 ns into a cycle where ce is high.
    task automatic wait_ce_cycle();
        @(posedge clock);
        #2;
        for (int i = 0; i < 8 && !ce; i++) begin
            @(posedge clock);
            #2;
        end
        check("ce_align", 0, ce, 1);
    endtask

    // Issues one request aligned to a ce edge; returns 2 ns into cycle 0 after transfer.
    task automatic xfer(input int port, input logic we, input logic [3:0] addr, input logic [7:0] wdata);
        wait_ce_cycle();
        if (port == 0) begin
            r0_valid = 1'b1; r0_we = we; r0_addr = addr; r0_wdata = wdata;
        end else begin
            r1_valid = 1'b1; r1_we = we; r1_addr = addr; r1_wdata = wdata;
        end
        @(negedge clock);
        check("ready_on_req", 0, (port == 0) ? r0_ready_o[0] : r1_ready_o[0], 1);
        @(posedge clock);
        #2;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
    endtask

    task automatic chk_bus(input string nm, input logic [1:0] bus, input logic [7:0] d, input logic bsy);
        check({nm, "_bus"}, 0, {bdir_o[0], bc1_o[0]}, bus);
        check({nm, "_d"}, 0, d_o[0], d);
        check({nm, "_busy"}, 0, busy_o[0], bsy);
    endtask

    initial begin
        logic [1:0] eb;
        logic [7:0] ed;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;
        cmp_en = 1'b1;
        @(negedge clock);
        chk_bus("rst", 2'b00, 8'h00, 1'b0);
        check("rst_ready0", 0, r0_ready_o[0], 0);
        check("rst_rvalid0", 0, r0_rvalid_o[0], 0);
        check("rst_rdata0", 0, r0_rdata_o[0], 0);
        check("rst_rdata1", 0, r1_rdata_o[0], 0);

        // Uncached write R8 = 0x1F: four phases, four clocks each.
        xfer(0, 1'b1, 4'd8, 8'h1F);
        for (int i = 0; i <= 16; i++) begin
            @(negedge clock);
            case (i / 4)
                0:       begin eb = 2'b11; ed = 8'h08; end
                2:       begin eb = 2'b10; ed = 8'h1F; end
                default: begin eb = 2'b00; ed = 8'h00; end
            endcase
            chk_bus("wr8", eb, ed, i < 16);
            if (i == 0) check("wr8_ready_drop", 0, r0_ready_o[0], 0);
        end

        // Back-to-back R13 writes from port 1; the second hits the address cache.
        wait_ce_cycle();
        r1_valid = 1'b1; r1_we = 1'b1; r1_addr = R_ENV_SHAPE; r1_wdata = 8'h0E;
        @(posedge clock);
        #2;
        for (int i = 0; i <= 24; i++) begin
            @(negedge clock);
            eb = 2'b00; ed = 8'h00;
            if (i < 4) begin eb = 2'b11; ed = 8'h0D; end
            else if ((i >= 8 && i < 12) || (i >= 17 && i < 20)) begin eb = 2'b10; ed = 8'h0E; end
            chk_bus("r13", eb, ed, !(i == 16 || i == 24));
            if (i == 16) check("r13_ready_idle", 0, r1_ready_o[0], 1);
            if (i == 17) r1_valid = 1'b0;
        end

        // Port 0 reads R7; data captured on the DATA exit edge.
        psg_q = 8'hB8;
        xfer(0, 1'b0, R_MIXER, 8'h00);
        for (int i = 0; i <= 16; i++) begin
            @(negedge clock);
            case (i / 4)
                0:       begin eb = 2'b11; ed = 8'h07; end
                2:       begin eb = 2'b01; ed = 8'h00; end
                default: begin eb = 2'b00; ed = 8'h00; end
            endcase
            chk_bus("rd7", eb, ed, i < 16);
            check("rd7_rvalid0", 0, r0_rvalid_o[0], i == 12);
            check("rd7_rvalid1", 0, r1_rvalid_o[0], 0);
            if (i == 12) check("rd7_rdata", 0, r0_rdata_o[0], 8'hB8);
            if (i == 13) psg_q = 8'h55;
            if (i == 15) check("rd7_hold", 0, r0_rdata_o[0], 8'hB8);
        end

        // ce stalled for 50 clocks while in ADDR.
        xfer(1, 1'b1, 4'd9, 8'h3C);
        ce_run = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            chk_bus("frz", 2'b11, 8'h09, 1'b1);
        end
        ce_run = 1'b1;
        repeat (30) @(negedge clock);
        chk_bus("frz_done", 2'b00, 8'h00, 1'b0);

        // Reset during the DATA phase of a read drops it and clears the cache.
        psg_q = 8'h66;
        xfer(0, 1'b0, R_MIXER, 8'h00);
        for (int i = 0; i <= 14; i++) begin
            @(negedge clock);
            if (i == 9) reset = 1'b1;
            if (i == 10) begin
                chk_bus("rst_mid", 2'b00, 8'h00, 1'b0);
                reset = 1'b0;
            end
            if (i >= 10) check("rst_mid_rvalid", 0, r0_rvalid_o[0], 0);
            if (i == 11) check("rst_mid_rdata", 0, r0_rdata_o[0], 0);
        end
        xfer(0, 1'b0, R_MIXER, 8'h00);
        for (int i = 0; i <= 16; i++) begin
            @(negedge clock);
            if (i == 0) chk_bus("rst_readdr", 2'b11, 8'h07, 1'b1);
            if (i == 12) check("rst_reread", 0, r0_rdata_o[0], 8'h66);
        end

        // Contention: both ports held valid.
        @(posedge clock);
        #2;
        reset = 1'b1;
        @(posedge clock);
        #2;
        reset = 1'b0;
        log_a.delete();
        log_b.delete();
        r0_valid = 1'b1; r0_we = 1'b1; r0_addr = 4'd2; r0_wdata = 8'h22;
        r1_valid = 1'b1; r1_we = 1'b1; r1_addr = 4'd3; r1_wdata = 8'h33;
        repeat (90) @(posedge clock);
        #2;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        repeat (40) @(negedge clock);
        check("rr_count", 0, log_a.size() >= 4, 1);
        if (log_a.size() >= 4) begin
            check("rr_g0", 0, log_a[0], 0);
            check("rr_g1", 0, log_a[1], 1);
            check("rr_g2", 0, log_a[2], 0);
            check("rr_g3", 0, log_a[3], 1);
        end
        check("fix_count", 1, log_b.size() >= 3, 1);
        begin
            int ones;
            ones = 0;
            foreach (log_b[i]) if (log_b[i] == 1) ones++;
            check("fix_r1_never", 1, ones, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
